// File: rtl/mult_div_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
// Optional divider support is enabled by defining MULT_DIV_DIV_EN.
package mult_div_pkg;

  localparam int MULT_DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_step.sv
// One iteration of the {HI,LO} accumulator: shift-add for multiply, restoring
// shift-subtract for divide (divide path present only with MULT_DIV_DIV_EN).
module mult_div_step
  import mult_div_pkg::*;
#(
  parameter int WIDTH = MULT_DIV_WIDTH
) (
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] b,
  input  logic             div_mode,
  output logic [WIDTH-1:0] hi_n,
  output logic [WIDTH-1:0] lo_n
);

  logic [WIDTH:0] sum;
`ifdef MULT_DIV_DIV_EN
  logic [WIDTH+1:0] diff;
`endif

  always_comb begin
    // Multiply: add multiplicand when the multiplier LSB is set, then shift right.
    sum  = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
    hi_n = sum[WIDTH:1];
    lo_n = {sum[0], lo[WIDTH-1:1]};
`ifdef MULT_DIV_DIV_EN
    diff = {1'b0, hi, lo[WIDTH-1]} - {2'b00, b};
    if (div_mode) begin
      if (diff[WIDTH+1]) begin
        hi_n = {hi[WIDTH-2:0], lo[WIDTH-1]};
        lo_n = {lo[WIDTH-2:0], 1'b0};
      end else begin
        hi_n = diff[WIDTH-1:0];
        lo_n = {lo[WIDTH-2:0], 1'b1};
      end
    end
`endif
  end

`ifndef MULT_DIV_DIV_EN
  logic unused_div_mode;
  assign unused_div_mode = div_mode;
`endif

endmodule

// File: rtl/mult_div.sv
// Iterative multiply/divide unit: WIDTH-cycle RUN, one-cycle sign FIX, DONE.
// Handshake: start is a one-cycle request taken only in IDLE or DONE; done is a one-cycle result-valid pulse; busy covers RUN and FIX. MULT_DIV_DIV_EN enables DIV/DIVU.
module mult_div
  import mult_div_pkg::*;
#(
  parameter int WIDTH = MULT_DIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             div_zero,
  output logic [1:0]       dbg_state
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             div_q, div_d, neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic             dz_q, dz_d, busy_q, busy_d, done_q, done_d, div_zero_q, div_zero_d;

  logic             in_signed;
  logic [WIDTH-1:0] mag_a, mag_b, step_hi, step_lo;

  assign in_signed = op_is_signed(op);
  assign mag_a     = (in_signed && A[WIDTH-1]) ? -A : A;
  assign mag_b     = (in_signed && B[WIDTH-1]) ? -B : B;

  mult_div_step #(.WIDTH(WIDTH)) u_step (
    .hi       (acc_hi_q),
    .lo       (acc_lo_q),
    .b        (b_q),
    .div_mode (div_q),
    .hi_n     (step_hi),
    .lo_n     (step_lo)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    b_d        = b_q;
    div_d      = div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    dz_d       = dz_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = div_zero_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE) begin
          hi_d       = acc_hi_q;
          lo_d       = acc_lo_q;
          div_zero_d = dz_q;
          done_d     = 1'b1;
          state_d    = S_IDLE;
        end
        if (start) begin
          div_d     = op_is_div(op);
          b_d       = mag_b;
          acc_hi_d  = '0;
          acc_lo_d  = mag_a;
          neg_res_d = in_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
          neg_rem_d = in_signed & A[WIDTH-1];
          dz_d      = 1'b0;
          cnt_d     = CNT_W'(WIDTH);
          state_d   = S_RUN;
          if (op_is_div(op)) begin
`ifdef MULT_DIV_DIV_EN
            if (B == '0) begin
              acc_hi_d = A;
              acc_lo_d = '1;
              dz_d     = 1'b1;
              cnt_d    = '0;
              state_d  = S_DONE;
            end
`else
            acc_hi_d = '0;
            acc_lo_d = '0;
            cnt_d    = '0;
            state_d  = S_DONE;
`endif
          end
        end
      end
      S_RUN: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        // Quotient takes the XOR of signs; remainder follows the dividend.
        if (div_q) begin
          if (neg_res_q) acc_lo_d = -acc_lo_q;
          if (neg_rem_q) acc_hi_d = -acc_hi_q;
        end else if (neg_res_q) begin
          {acc_hi_d, acc_lo_d} = -{acc_hi_q, acc_lo_q};
        end
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN) || (state_d == S_FIX);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      b_q        <= '0;
      div_q      <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      b_q        <= b_d;
      div_q      <= div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      dz_q       <= dz_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign HI        = hi_q;
  assign LO        = lo_q;
  assign div_zero  = div_zero_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mult_div.sv
// Self-checking bench for mult_div: directed corner cases, randomized ops against
// an arithmetic reference model, back-to-back, ignored start and reset abort.
module tb_mult_div;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] HI, LO;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_fail = 0;

  mult_div #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .op        (op),
    .A         (A),
    .B         (B),
    .busy      (busy),
    .done      (done),
    .HI        (HI),
    .LO        (LO),
    .div_zero  (div_zero),
    .dbg_state (dbg_state)
  );

  always #5 clock = ~clock;

  // Reference model: plain 64-bit arithmetic, SV division truncates toward zero.
  function automatic void model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] e_hi, output logic [W-1:0] e_lo,
                                output bit e_dz, output int e_lat);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    logic [2*W-1:0]  p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    e_dz  = 1'b0;
    e_lat = W + 2;
    e_hi  = '0;
    e_lo  = '0;
    if (o == 2'd0 || o == 2'd1) begin
      p = (o == 2'd0) ? 64'(sa * sb) : 64'(ua * ub);
      e_hi = p[2*W-1:W];
      e_lo = p[W-1:0];
    end else begin
      e_lat = 1;
`ifdef MULT_DIV_DIV_EN
      if (b == '0) begin
        e_hi = a;
        e_lo = '1;
        e_dz = 1'b1;
      end else begin
        e_lat = W + 2;
        if (o == 2'd2) begin
          q = sa / sb;
          r = sa % sb;
          e_lo = W'(q);
          e_hi = W'(r);
        end else begin
          e_lo = W'(ua / ub);
          e_hi = W'(ua % ub);
        end
      end
`endif
    end
  endfunction

  // Issues one op and waits for done; lat is edges from acceptance to the DONE edge.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit scramble, output int lat);
    int n;
    @(negedge clock);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clock);
    start = 1'b0;
    n = 1;
    while (!done && n < 200) begin
      if (scramble) begin
        A = $urandom; B = $urandom; op = 2'($urandom_range(0, 3));
      end
      @(negedge clock);
      n++;
    end
    lat = n - 1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b1; op = 2'd1; A = '1; B = '1;
    repeat (3) @(negedge clock);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (HI !== '0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", HI); end
    n_checks++; if (LO !== '0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", LO); end
    n_checks++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL reset_div_zero: got %b want 0", div_zero); end
    n_checks++; if (dbg_state !== 2'b00) begin n_fail++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    start = 1'b0; reset_n = 1'b1;
    @(negedge clock);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy: got %b want 0", busy); end
  endtask

  task automatic test_directed();
    logic [1:0]   v_op [8];
    logic [W-1:0] v_a [8];
    logic [W-1:0] v_b [8];
    logic [W-1:0] e_hi, e_lo;
    bit           e_dz;
    int           e_lat, lat;
    v_op = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd2, 2'd3, 2'd0, 2'd1};
    v_a  = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd100,
             32'h8000_0000, 32'd5, 32'h8000_0000, 32'd0};
    v_b  = '{32'hFFFF_FFFF, 32'd7, 32'd2, 32'd7,
             32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 32'h1234_5678};
    for (int i = 0; i < 8; i++) begin
      model(v_op[i], v_a[i], v_b[i], e_hi, e_lo, e_dz, e_lat);
      run_op(v_op[i], v_a[i], v_b[i], 1'b0, lat);
      n_checks++; if (lat !== e_lat) begin n_fail++; $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, e_lat); end
      n_checks++; if (HI !== e_hi) begin n_fail++; $display("FAIL directed_hi[%0d]: got %h want %h", i, HI, e_hi); end
      n_checks++; if (LO !== e_lo) begin n_fail++; $display("FAIL directed_lo[%0d]: got %h want %h", i, LO, e_lo); end
      n_checks++; if (div_zero !== e_dz) begin n_fail++; $display("FAIL directed_div_zero[%0d]: got %b want %b", i, div_zero, e_dz); end
      @(negedge clock);
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL directed_done_pulse[%0d]: got %b want 0", i, done); end
      n_checks++; if ({HI, LO} !== {e_hi, e_lo}) begin n_fail++; $display("FAIL directed_hold[%0d]: got %h want %h", i, {HI, LO}, {e_hi, e_lo}); end
    end
  endtask

  // A start during RUN must not restart the op; busy covers RUN and FIX only.
  task automatic test_ignore_start();
    logic [W-1:0] a, b, e_hi, e_lo;
    bit           e_dz;
    int           e_lat;
    a = $urandom; b = $urandom;
    model(2'd0, a, b, e_hi, e_lo, e_dz, e_lat);
    @(negedge clock);
    start = 1'b1; op = 2'd0; A = a; B = b;
    @(negedge clock);
    start = 1'b0;
    for (int n = 1; n <= W + 3; n++) begin
      if (n <= W + 1) begin
        n_checks++; if ({busy, done} !== 2'b10) begin n_fail++; $display("FAIL ignore_busy[%0d]: got busy=%b done=%b want busy=1 done=0", n, busy, done); end
      end else if (n == W + 2) begin
        n_checks++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL ignore_done_state: got busy=%b done=%b want 0 0", busy, done); end
      end else begin
        n_checks++; if ({busy, done} !== 2'b01) begin n_fail++; $display("FAIL ignore_done: got busy=%b done=%b want 0 1", busy, done); end
        n_checks++; if ({HI, LO} !== {e_hi, e_lo}) begin n_fail++; $display("FAIL ignore_result: got %h want %h", {HI, LO}, {e_hi, e_lo}); end
      end
      if (n == 5) begin start = 1'b1; op = 2'd3; A = 32'd1; B = '0; end
      if (n == 6) start = 1'b0;
      if (n < W + 3) @(negedge clock);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a1, b1, a2, b2, h1, l1, h2, l2;
    bit           dz;
    int           lat, n2;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
    model(2'd0, a1, b1, h1, l1, dz, lat);
    model(2'd1, a2, b2, h2, l2, dz, lat);
    @(negedge clock);
    start = 1'b1; op = 2'd0; A = a1; B = b1;
    @(negedge clock);
    start = 1'b0;
    repeat (W + 1) @(negedge clock);
    start = 1'b1; op = 2'd1; A = a2; B = b2;
    @(negedge clock);
    start = 1'b0;
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_first_done: got %b want 1", done); end
    n_checks++; if ({HI, LO} !== {h1, l1}) begin n_fail++; $display("FAIL b2b_first_result: got %h want %h", {HI, LO}, {h1, l1}); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_second_accepted: got busy=%b want 1", busy); end
    repeat (10) @(negedge clock);
    n_checks++; if ({HI, LO} !== {h1, l1}) begin n_fail++; $display("FAIL b2b_first_held: got %h want %h", {HI, LO}, {h1, l1}); end
    n2 = 11;
    while (!done && n2 < 200) begin @(negedge clock); n2++; end
    n_checks++; if (n2 - 1 !== W + 2) begin n_fail++; $display("FAIL b2b_second_latency: got %0d want %0d", n2 - 1, W + 2); end
    n_checks++; if ({HI, LO} !== {h2, l2}) begin n_fail++; $display("FAIL b2b_second_result: got %h want %h", {HI, LO}, {h2, l2}); end
  endtask

  task automatic test_random();
    logic [1:0]   o;
    logic [W-1:0] a, b, e_hi, e_lo;
    bit           e_dz;
    int           e_lat, lat;
    for (int i = 0; i < 30; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = 32'hFFFF_FFFF;
        2: a = 32'h8000_0000;
        3: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      model(o, a, b, e_hi, e_lo, e_dz, e_lat);
      run_op(o, a, b, 1'b1, lat);
      n_checks++; if (lat !== e_lat) begin n_fail++; $display("FAIL random_latency[%0d]: op=%0d got %0d want %0d", i, o, lat, e_lat); end
      n_checks++; if ({HI, LO} !== {e_hi, e_lo}) begin n_fail++; $display("FAIL random_result[%0d]: op=%0d a=%h b=%h got %h want %h", i, o, a, b, {HI, LO}, {e_hi, e_lo}); end
      n_checks++; if (div_zero !== e_dz) begin n_fail++; $display("FAIL random_div_zero[%0d]: got %b want %b", i, div_zero, e_dz); end
    end
  endtask

  task automatic test_abort();
    int  lat;
    bit  seen;
    run_op(2'd1, 32'd3, 32'd5, 1'b0, lat);
    n_checks++; if (LO !== 32'd15) begin n_fail++; $display("FAIL abort_pre_result: got %h want %h", LO, 32'd15); end
    @(negedge clock);
    start = 1'b1; op = 2'd0; A = 32'd12345; B = 32'd678;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    start = 1'b1; op = 2'd3; A = 32'd9; B = 32'd0;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_mid_run_busy: got %b want 1", busy); end
    @(negedge clock);
    reset_n = 1'b0; start = 1'b1; op = 2'd1; A = 32'd2; B = 32'd2;
    seen = 1'b0;
    repeat (3) begin @(negedge clock); if (done) seen = 1'b1; end
    reset_n = 1'b1; start = 1'b0;
    for (int n = 0; n < W + 8; n++) begin @(negedge clock); if (done) seen = 1'b1; end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got done seen=%b want 0", seen); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_checks++; if ({HI, LO} !== '0) begin n_fail++; $display("FAIL abort_result: got %h want 0", {HI, LO}); end
    n_checks++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL abort_div_zero: got %b want 0", div_zero); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_random();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div.md
MULT_DIV -- requirements
Module: mult_div

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width.
REQ-002 The block SHALL have port clock, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port reset_n, input, 1, a synchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, a one-cycle operation request.
REQ-005 The block SHALL have port op, input, 2, the operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 The block SHALL have ports A and B, input, WIDTH, the operands sampled with start.
REQ-007 The block SHALL have port busy, output, 1, high while an operation is in progress.
REQ-008 The block SHALL have port done, output, 1, a one-cycle result-valid pulse.
REQ-009 The block SHALL have ports HI and LO, output, WIDTH, the result registers.
REQ-010 The block SHALL have port div_zero, output, 1, flagging the last division as having divisor 0.

Function
REQ-011 The FSM SHALL use states IDLE, RUN, FIX and DONE; start SHALL be accepted only in IDLE or DONE and ignored otherwise.
REQ-012 On acceptance the block SHALL register op and the operand magnitudes (absolute values for signed ops) plus the result sign, load the counter with WIDTH, and enter RUN.
REQ-013 RUN SHALL last exactly WIDTH cycles, with one shift-add (multiply) or one restoring shift-subtract (divide) step per cycle, then go to FIX.
REQ-014 FIX SHALL apply the sign correction in one cycle: negate the 2*WIDTH product if the operand signs differ; negate the quotient if the signs differ; give the remainder the dividend's sign.
REQ-015 DONE SHALL last one cycle, update HI/LO and assert done, and return to IDLE unless start is asserted.
REQ-016 Total latency SHALL be start sampled at edge k to done high in the cycle after edge k+WIDTH+2; busy SHALL be high in RUN and FIX only.
REQ-017 Multiply results SHALL be HI = product[2W-1:W] and LO = product[W-1:0]; divide results SHALL be LO = quotient and HI = remainder.
REQ-018 For DIV/DIVU with B==0, the block SHALL skip RUN/FIX and enter DONE on the next edge, with LO = all ones, HI = A, and div_zero = 1.
REQ-019 div_zero SHALL otherwise be 0 at each done.
REQ-020 DIV of the most negative value by -1 SHALL give LO = the most negative value and HI = 0, with no flag.
REQ-021 HI, LO and div_zero SHALL hold between done pulses; A, B and op changes during busy SHALL have no effect.

Reset
REQ-022 reset_n low at a clock edge SHALL force IDLE with busy=0, done=0, HI=0, LO=0, div_zero=0, and the counter cleared.
REQ-023 A reset during RUN or FIX SHALL abort the operation with no done pulse, and start SHALL be ignored while reset_n is low.

Configuration
REQ-024 With macro MULT_DIV_DIV_EN defined, all four ops SHALL be supported.
REQ-025 With MULT_DIV_DIV_EN undefined, the divider datapath SHALL be absent, and DIV/DIVU SHALL go straight to DONE with HI=0, LO=0 and div_zero=0.

Structure
REQ-026 The op encodings, state encodings and WIDTH default SHALL live in the shared package/include used by the EX-stage blocks.
REQ-027 The per-cycle iteration datapath SHALL be a sub-module mult_div_step: a combinational add-or-subtract-and-shift of {HI,LO}, instantiated once.

Verification
REQ-028 MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> done after WIDTH+2 cycles with HI=0xFFFFFFFE and LO=0x00000001.
REQ-029 MULT A=-3, B=7 -> HI=0xFFFFFFFF and LO=0xFFFFFFEB.
REQ-030 DIV A=-7, B=2 -> LO=0xFFFFFFFD and HI=0xFFFFFFFF; DIVU A=100, B=7 -> LO=14 and HI=2.
REQ-031 DIVU A=5, B=0 -> done one cycle after acceptance with div_zero=1, LO=0xFFFFFFFF and HI=5.
REQ-032 start a MULT, pulse start again mid-RUN, then drop reset_n at RUN cycle 10 -> the second start is ignored, no done occurs, and all outputs are 0.
REQ-033 Back-to-back ops with start held in DONE -> the second op is accepted, and the first result stays on HI/LO until the second done.
